snoop_bus_ctrl: RTL and testbench
=================================

Name: snoop_bus_ctrl

Overview:
- Shared-bus responder and backing memory for the two-cache MSI snoopy system. The peer caches act as initiators.
- Arbitrates line-level requests from cache 0 and cache 1: GetS (read miss), GetM (write miss), Inv (upgrade) and PutM (write-back).
- Broadcasts each coherence request as a snoop to the non-requesting cache and collects its hit/dirty reply.
- Sources the line from the dirty peer or from internal memory, then returns a one-cycle response to the requester.

Parameters:
- ADDR_W, 6, line address width ({tag, index}); memory depth is 2**ADDR_W.
- DATA_W, 32, line width.
- MEM_LAT, 2, memory access cycles (>=1).
- SNOOP_TIMEOUT, 4, maximum snoop_valid cycles before a missing ack is treated as a miss (>=1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  2  per-cache request valid; held until the request is granted.
- req_op  in  2x2  per-cache op: 00 GetS, 01 GetM, 10 Inv, 11 PutM.
- req_addr  in  2xADDR_W  per-cache line address.
- req_data  in  2xDATA_W  per-cache write-back data (PutM only).
- req_gnt  out  2  combinational; accept on req_valid & req_gnt.
- resp_valid  out  2  one-cycle response pulse to the requester.
- resp_data  out  DATA_W  line data (GetS/GetM); 0 for Inv/PutM.
- resp_shared  out  1  peer held the line at snoop time (GetS only).
- snoop_valid  out  2  snoop to the non-requester; held until ack or timeout.
- snoop_op  out  2  latched op forwarded to the peer.
- snoop_addr  out  ADDR_W  latched line address.
- snoop_ack  in  2  peer reply strobe.
- snoop_hit  in  2  peer has the line valid.
- snoop_dirty  in  2  peer has the line modified; supplies data.
- snoop_data  in  2xDATA_W  peer line data, valid with ack & dirty.

Behaviour:
- Reset:
  - State IDLE, rr_ptr=0, all outputs 0.
  - Every memory line cleared to 0 over the reset cycle. The bench holds reset for 1+ cycle.
  - Reset mid-transaction aborts it: no memory write, no resp_valid.
- States: IDLE, SNOOP, MEM, RESP.
- IDLE arbitration:
  - Round-robin; the winner is the first valid requester starting at rr_ptr.
  - req_gnt[winner]=1, one-hot, only in IDLE.
  - On accept: latch id/op/addr/data and set rr_ptr = ~winner.
  - PutM goes to MEM (write); all other ops go to SNOOP.
- SNOOP:
  - snoop_valid[~id]=1 with snoop_op/snoop_addr; a timer counts cycles.
  - An ack is sampled in any SNOOP cycle, including the first.
  - On ack, latch hit into the shared flag.
  - If dirty: write snoop_data into memory at addr on the same edge, latch it as resp data, and go to RESP.
  - Else if op is Inv: go to RESP.
  - Else: go to MEM (read).
  - On timeout (SNOOP_TIMEOUT cycles with no ack): treat as hit=0/dirty=0.
  - Peer self-invalidation on GetM/Inv and the dirty-to-shared transition on GetS are the peer's responsibility.
- MEM:
  - Stays exactly MEM_LAT cycles.
  - On the last cycle, either writes req_data (PutM) or latches mem[addr] (read).
  - Then goes to RESP.
- RESP:
  - resp_valid[id]=1 for one cycle.
  - resp_shared = latched hit & (op==GetS).
  - Next state is IDLE; the next grant comes no earlier than the cycle after RESP.
- Latency, grant at cycle T:
  - Dirty-peer GetS/GetM: RESP at T+2.
  - Clean GetS: RESP at T+2+MEM_LAT.
  - Inv with immediate ack: RESP at T+2.
  - PutM: RESP at T+1+MEM_LAT.
- Boundaries:
  - Both requesting in IDLE: rr_ptr decides; the loser's req_valid stays high and it wins the next IDLE.
  - A request from the snooped cache is not granted while its snoop is outstanding.
  - Ack arriving outside SNOOP is ignored.
  - A late ack after timeout is ignored; the peer must not assume its data was taken.
  - Addresses use full ADDR_W range; 6'h3F is legal.
  - A simultaneous ack & dirty with op Inv still writes memory and returns no data.

Decomposition:
- Package snoop_bus_pkg: op encodings (OP_GETS, OP_GETM, OP_INV, OP_PUTM), state encodings, and ADDR_W/DATA_W defaults.
- Sub-module snoop_bus_arb: 2-way round-robin arbiter (req, advance -> one-hot gnt, rr_ptr).
- Memory array and FSM stay in the top level.

Test Plan:
- Reset, then cache0 GetS addr 6'h05, peer ack hit=0 at first SNOOP cycle -> resp_valid[0] at T+4, resp_data=32'h0, resp_shared=0.
- Cache1 PutM addr 6'h05 data 32'hDEADBEEF, then cache0 GetS 6'h05 with peer miss -> resp_data=32'hDEADBEEF, PutM resp at T+3.
- Cache0 GetM 6'h12, peer ack dirty data 32'hCAFE0001 -> resp_valid[0] at T+2 with 32'hCAFE0001. A later GetS 6'h12 with peer miss returns 32'hCAFE0001 from memory.
- Both req_valid high in the same cycle after reset -> cache0 granted first, cache1 granted in the IDLE following cache0's RESP. Repeat -> cache1 wins the next tie.
- Peer never acks a GetS -> snoop_valid held exactly 4 cycles, then memory read, resp_shared=0. An ack one cycle later is ignored.
- Reset asserted during MEM of PutM 6'h20 data 32'h1234 -> no resp_valid; after reset, GetS 6'h20 returns 32'h0.

Source files
------------

// File: rtl/snoop_bus_pkg.sv
// Shared encodings for the two-cache MSI snoop bus controller.
// Holds the request opcodes, FSM states and default bus widths.
package snoop_bus_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OP_GETS = 2'b00,
        OP_GETM = 2'b01,
        OP_INV  = 2'b10,
        OP_PUTM = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        SNOOP,
        MEM,
        RESP
    } state_e;

endpackage

// File: rtl/snoop_bus_arb.sv
// Two-way round-robin arbiter: grants the first valid requester from rr_ptr,
// then points rr_ptr away from the winner once the grant is taken.
module snoop_bus_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic rr_ptr;
    logic win;
    logic any;

    always_comb begin
        gnt = '0;
        win = rr_ptr;
        any = 1'b0;
        if (req[rr_ptr]) begin
            win = rr_ptr;
            any = 1'b1;
        end else if (req[~rr_ptr]) begin
            win = ~rr_ptr;
            any = 1'b1;
        end
        if (enable && any) begin
            gnt[win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (advance && (|gnt)) begin
            rr_ptr <= ~win;
        end
    end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Shared-bus responder and backing memory for two MSI snoopy caches:
// arbitrates requests, snoops the peer, sources data, answers the requester.
module snoop_bus_ctrl
    import snoop_bus_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int MEM_LAT       = 2,
    parameter int SNOOP_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    input  logic [1:0][1:0]        req_op,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_data,
    output logic [1:0]             req_gnt,
    output logic [1:0]             resp_valid,
    output logic [DATA_W-1:0]      resp_data,
    output logic                   resp_shared,
    output logic [1:0]             snoop_valid,
    output logic [1:0]             snoop_op,
    output logic [ADDR_W-1:0]      snoop_addr,
    input  logic [1:0]             snoop_ack,
    input  logic [1:0]             snoop_hit,
    input  logic [1:0]             snoop_dirty,
    input  logic [1:0][DATA_W-1:0] snoop_data
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int          CNT_MAX = (MEM_LAT > SNOOP_TIMEOUT) ? MEM_LAT : SNOOP_TIMEOUT;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);

    state_e              state, state_next;
    logic                id_q;
    op_e                 op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                hit_q;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic accept;
    logic ack_take;
    logic win;
    logic peer;
    logic snoop_last;
    logic mem_last;

    assign win        = req_gnt[1];
    assign peer       = ~id_q;
    assign snoop_last = (cnt == CNT_W'(SNOOP_TIMEOUT - 1));
    assign mem_last   = (cnt == CNT_W'(MEM_LAT - 1));

    snoop_bus_arb u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .enable  ((state == IDLE) && !reset),
        .advance (accept),
        .gnt     (req_gnt)
    );

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        ack_take    = 1'b0;
        resp_valid  = '0;
        resp_data   = '0;
        resp_shared = 1'b0;
        snoop_valid = '0;
        snoop_op    = '0;
        snoop_addr  = '0;
        case (state)
            IDLE: begin
                if (|req_gnt) begin
                    accept     = 1'b1;
                    state_next = (op_e'(req_op[win]) == OP_PUTM) ? MEM : SNOOP;
                end
            end
            SNOOP: begin
                snoop_valid[peer] = 1'b1;
                snoop_op          = op_q;
                snoop_addr        = addr_q;
                // Only the snooped peer's ack counts; a dirty reply bypasses memory.
                if (snoop_ack[peer]) begin
                    ack_take   = 1'b1;
                    state_next = (snoop_dirty[peer] || op_q == OP_INV) ? RESP : MEM;
                end else if (snoop_last) begin
                    state_next = (op_q == OP_INV) ? RESP : MEM;
                end
            end
            MEM: begin
                if (mem_last) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid[id_q] = 1'b1;
                if (op_q == OP_GETS || op_q == OP_GETM) begin
                    resp_data = rdata_q;
                end
                resp_shared = hit_q && (op_q == OP_GETS);
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            id_q    <= 1'b0;
            op_q    <= OP_GETS;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hit_q   <= 1'b0;
            cnt     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i[ADDR_W-1:0]] <= '0;
            end
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + 1'b1;
            if (accept) begin
                id_q    <= win;
                op_q    <= op_e'(req_op[win]);
                addr_q  <= req_addr[win];
                wdata_q <= req_data[win];
                hit_q   <= 1'b0;
                rdata_q <= '0;
            end
            if (ack_take) begin
                hit_q <= snoop_hit[peer];
                if (snoop_dirty[peer]) begin
                    mem[addr_q] <= snoop_data[peer];
                    rdata_q     <= snoop_data[peer];
                end
            end
            if (state == MEM && mem_last) begin
                if (op_q == OP_PUTM) begin
                    mem[addr_q] <= wdata_q;
                end else begin
                    rdata_q <= mem[addr_q];
                end
            end
        end
    end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Randomized bench for snoop_bus_ctrl: acts as both caches and the snooped
// peer, predicting grants, snoop windows and responses from a transaction model.
module tb_snoop_bus_ctrl;
    import snoop_bus_pkg::*;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;
    localparam int TO      = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [1:0]             req_valid = '0;
    logic [1:0][1:0]        req_op = '0;
    logic [1:0][ADDR_W-1:0] req_addr = '0;
    logic [1:0][DATA_W-1:0] req_data = '0;
    logic [1:0]             req_gnt;
    logic [1:0]             resp_valid;
    logic [DATA_W-1:0]      resp_data;
    logic                   resp_shared;
    logic [1:0]             snoop_valid;
    logic [1:0]             snoop_op;
    logic [ADDR_W-1:0]      snoop_addr;
    logic [1:0]             snoop_ack = '0;
    logic [1:0]             snoop_hit = '0;
    logic [1:0]             snoop_dirty = '0;
    logic [1:0][DATA_W-1:0] snoop_data = '0;

    always #5 clk = ~clk;

    snoop_bus_ctrl #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .MEM_LAT       (MEM_LAT),
        .SNOOP_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_gnt     (req_gnt),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_shared (resp_shared),
        .snoop_valid (snoop_valid),
        .snoop_op    (snoop_op),
        .snoop_addr  (snoop_addr),
        .snoop_ack   (snoop_ack),
        .snoop_hit   (snoop_hit),
        .snoop_dirty (snoop_dirty),
        .snoop_data  (snoop_data)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    logic [DATA_W-1:0] mem_m [64];
    logic              rr_m;
    logic              pend [2];
    logic              drop_next [2];
    logic [1:0]        p_op [2];
    logic [ADDR_W-1:0] p_addr [2];
    logic [DATA_W-1:0] p_data [2];
    logic              q_have [2];
    logic [1:0]        q_op [2];
    logic [ADDR_W-1:0] q_addr [2];
    logic [DATA_W-1:0] q_data [2];

    int t_g, t_resp, s_len, ack_at, late_at;
    logic              cid;
    logic [1:0]        c_op;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] exp_data;
    logic              exp_shared;
    logic              ack_hit, ack_dirty;
    logic [DATA_W-1:0] ack_data;

    logic              f_have;
    int                f_delay;
    logic              f_hit, f_dirty, f_late;
    logic [DATA_W-1:0] f_data;
    logic              rand_on  = 1'b0;
    logic              noise_on = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mem_m[i] = '0;
        rr_m = 1'b0;
        for (int c = 0; c < 2; c++) begin
            pend[c] = 1'b0; drop_next[c] = 1'b0; q_have[c] = 1'b0;
        end
        req_valid = '0;
        t_g = -1000; t_resp = -1000; s_len = 0; ack_at = -1000; late_at = -1000;
        cid = 1'b0; c_op = '0; c_addr = '0; exp_data = '0; exp_shared = 1'b0;
        f_have = 1'b0;
    endtask

    task automatic post_now(input int c, input logic [1:0] op, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        pend[c] = 1'b1; p_op[c] = op; p_addr[c] = a; p_data[c] = d;
        req_valid[c] = 1'b1; req_op[c] = op; req_addr[c] = a; req_data[c] = d;
    endtask

    task automatic force_peer(input int d, input logic h, input logic dt, input logic l,
                              input logic [DATA_W-1:0] data);
        f_have = 1'b1; f_delay = d; f_hit = h; f_dirty = dt; f_late = l; f_data = data;
    endtask

    // Model of one granted transaction: latency, snoop window and result data.
    task automatic start_txn(input logic w);
        int delay;
        logic hit, dirty, late, acked, dirty_eff;
        cid = w; c_op = p_op[w]; c_addr = p_addr[w]; t_g = cyc;
        pend[w] = 1'b0; drop_next[w] = 1'b1; rr_m = !w;
        if (f_have) begin
            delay = f_delay; hit = f_hit; dirty = f_dirty; late = f_late; ack_data = f_data;
            f_have = 1'b0;
        end else begin
            delay = int'($urandom_range(0, 5));
            dirty = ($urandom_range(0, 2) == 0);
            hit   = dirty | 1'($urandom);
            late  = 1'($urandom);
            ack_data = $urandom;
        end
        ack_hit = hit; ack_dirty = dirty; ack_at = -1000; late_at = -1000;
        if (c_op == OP_PUTM) begin
            s_len = 0;
            mem_m[c_addr] = p_data[w];
            exp_data = '0; exp_shared = 1'b0;
            t_resp = t_g + 1 + MEM_LAT;
        end else begin
            acked = (delay < TO);
            s_len = acked ? delay + 1 : TO;
            if (acked) ack_at = t_g + 1 + delay;
            if (late) late_at = t_g + 1 + s_len;
            dirty_eff = acked && dirty;
            if (dirty_eff) mem_m[c_addr] = ack_data;
            t_resp = t_g + 1 + s_len + ((dirty_eff || c_op == OP_INV) ? 0 : MEM_LAT);
            exp_data = (c_op == OP_GETS || c_op == OP_GETM) ? mem_m[c_addr] : '0;
            exp_shared = acked && hit && (c_op == OP_GETS);
        end
    endtask

    task automatic drive_peer();
        logic p;
        logic in_win;
        p = !cid;
        in_win = (cyc > t_g) && (cyc <= t_g + s_len);
        snoop_ack = '0; snoop_hit = '0; snoop_dirty = '0;
        snoop_data = {$urandom, $urandom};
        for (int c = 0; c < 2; c++) begin
            if (noise_on && !(in_win && c == int'(p))) begin
                snoop_ack[c]   = ($urandom_range(0, 3) == 0);
                snoop_hit[c]   = 1'($urandom);
                snoop_dirty[c] = 1'($urandom);
            end
        end
        if (in_win) begin
            snoop_hit[p] = 1'($urandom); snoop_dirty[p] = 1'($urandom);
        end
        if (cyc == ack_at) begin
            snoop_ack[p] = 1'b1; snoop_hit[p] = ack_hit; snoop_dirty[p] = ack_dirty;
            snoop_data[p] = ack_data;
        end else if (cyc == late_at) begin
            snoop_ack[p] = 1'b1; snoop_hit[p] = 1'b1; snoop_dirty[p] = 1'b1;
        end
    endtask

    task automatic tick();
        logic [1:0] exp_gnt, exp_rv, exp_sv;
        logic w, have_w;
        logic [ADDR_W-1:0] ra;
        @(negedge clk);
        cyc++;
        for (int c = 0; c < 2; c++) begin
            if (drop_next[c]) begin req_valid[c] = 1'b0; drop_next[c] = 1'b0; end
            if (q_have[c]) begin post_now(c, q_op[c], q_addr[c], q_data[c]); q_have[c] = 1'b0; end
            if (rand_on && !pend[c] && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       ra = 6'h3F;
                    1:       ra = 6'($urandom);
                    default: ra = 6'($urandom_range(0, 7));
                endcase
                post_now(c, 2'($urandom_range(0, 3)), ra, $urandom);
            end
        end
        drive_peer();
        #1;
        exp_gnt = '0; have_w = 1'b0; w = 1'b0;
        if (!reset && cyc > t_resp) begin
            if (pend[rr_m])       begin w = rr_m;  have_w = 1'b1; end
            else if (pend[!rr_m]) begin w = !rr_m; have_w = 1'b1; end
            if (have_w) exp_gnt[w] = 1'b1;
        end
        check("req_gnt", 64'(req_gnt), 64'(exp_gnt));
        exp_rv = '0;
        if (cyc == t_resp) exp_rv[cid] = 1'b1;
        check("resp_valid", 64'(resp_valid), 64'(exp_rv));
        if (cyc == t_resp) begin
            check("resp_data", 64'(resp_data), 64'(exp_data));
            check("resp_shared", 64'(resp_shared), 64'(exp_shared));
        end
        exp_sv = '0;
        if (cyc > t_g && cyc <= t_g + s_len) exp_sv[!cid] = 1'b1;
        check("snoop_valid", 64'(snoop_valid), 64'(exp_sv));
        if (s_len > 0 && cyc == t_g + 1) begin
            check("snoop_op", 64'(snoop_op), 64'(c_op));
            check("snoop_addr", 64'(snoop_addr), 64'(c_addr));
        end
        if (have_w) start_txn(w);
    endtask

    task automatic post(input int c, input logic [1:0] op, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
        int n = 0;
        while ((pend[c] || drop_next[c] || q_have[c]) && n < 100) begin tick(); n++; end
        q_have[c] = 1'b1; q_op[c] = op; q_addr[c] = a; q_data[c] = d;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pend[0] || pend[1] || q_have[0] || q_have[1] || cyc <= t_resp) && n < 300) begin
            tick(); n++;
        end
        check("idle_reached", 64'(pend[0] | pend[1] | q_have[0] | q_have[1] | (cyc <= t_resp)), 64'(0));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        clear_model();
        repeat (n) tick();
        reset = 1'b0;
    endtask

    initial begin
        int g0, n;
        clear_model();
        do_reset(2);

        // clean GetS of a cleared line, peer misses on first snoop cycle
        force_peer(0, 1'b0, 1'b0, 1'b0, '0);
        post(0, OP_GETS, 6'h05, '0);
        wait_idle();

        // write-back then read from memory
        post(1, OP_PUTM, 6'h05, 32'hDEADBEEF);
        wait_idle();
        force_peer(0, 1'b0, 1'b0, 1'b0, '0);
        post(0, OP_GETS, 6'h05, '0);
        wait_idle();

        // dirty peer supplies data and memory is updated
        force_peer(0, 1'b1, 1'b1, 1'b0, 32'hCAFE0001);
        post(0, OP_GETM, 6'h12, '0);
        wait_idle();
        force_peer(0, 1'b0, 1'b0, 1'b0, '0);
        post(0, OP_GETS, 6'h12, '0);
        wait_idle();

        // snoop timeout followed by an ignored late dirty ack
        force_peer(TO, 1'b1, 1'b1, 1'b1, 32'hBAD0BAD0);
        post(1, OP_GETS, 6'h05, '0);
        wait_idle();
        force_peer(1, 1'b0, 1'b0, 1'b0, '0);
        post(0, OP_GETS, 6'h05, '0);
        wait_idle();

        // Inv with dirty ack at top address writes memory, returns no data
        force_peer(2, 1'b1, 1'b1, 1'b0, 32'h55AA33CC);
        post(0, OP_INV, 6'h3F, '0);
        wait_idle();
        force_peer(0, 1'b1, 1'b0, 1'b0, '0);
        post(1, OP_GETS, 6'h3F, '0);
        wait_idle();

        // simultaneous requests after reset, then loser wins against a re-request
        do_reset(1);
        post(0, OP_GETS, 6'h01, '0);
        post(1, OP_GETS, 6'h02, '0);
        g0 = t_g; n = 0;
        while (t_g == g0 && n < 50) begin tick(); n++; end
        post(0, OP_GETM, 6'h03, '0);
        wait_idle();

        // reset during the MEM phase of a write-back
        post(1, OP_PUTM, 6'h20, 32'h00001234);
        g0 = t_g; n = 0;
        while (!(t_g != g0 && cyc == t_g + 1) && n < 50) begin tick(); n++; end
        check("putm_reached_mem", 64'(t_g != g0 && cyc == t_g + 1), 64'(1));
        do_reset(1);
        repeat (4) tick();
        force_peer(0, 1'b0, 1'b0, 1'b0, '0);
        post(0, OP_GETS, 6'h20, '0);
        wait_idle();

        // random traffic with bus noise
        rand_on = 1'b1; noise_on = 1'b1;
        repeat (2500) tick();
        rand_on = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1);
    end

endmodule
